// File: rtl/minmax_pkg.sv
// Shared constants and FSM encoding for the min/max scan sequencer.
// MINMAX_INDEX_EN (see minmax_scan_ctrl) adds first-occurrence index outputs.
package minmax_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/minmax_accum.sv
// Running min/max accumulator; *_nxt expose the value including the current sample.
// With MINMAX_INDEX_EN it also tracks the address of the first min/max occurrence.
module minmax_accum
    import minmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef MINMAX_INDEX_EN
    ,
    parameter int ADDR_W = ADDR_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              smp_vld,
    input  logic [DATA_W-1:0] smp_data,
`ifdef MINMAX_INDEX_EN
    input  logic [ADDR_W-1:0] smp_idx,
    output logic [ADDR_W-1:0] min_idx_nxt,
    output logic [ADDR_W-1:0] max_idx_nxt,
`endif
    output logic [DATA_W-1:0] min_nxt,
    output logic [DATA_W-1:0] max_nxt
);

    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
`ifdef MINMAX_INDEX_EN
    logic [ADDR_W-1:0] min_idx_q, min_idx_d;
    logic [ADDR_W-1:0] max_idx_q, max_idx_d;
`endif

    // Strict compares: a tie never replaces the earlier sample.
    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
`ifdef MINMAX_INDEX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        if (init) begin
            run_min_d = '1;
            run_max_d = '0;
`ifdef MINMAX_INDEX_EN
            min_idx_d = '0;
            max_idx_d = '0;
`endif
        end else if (smp_vld) begin
            if (smp_data < run_min_q) begin
                run_min_d = smp_data;
`ifdef MINMAX_INDEX_EN
                min_idx_d = smp_idx;
`endif
            end
            if (smp_data > run_max_q) begin
                run_max_d = smp_data;
`ifdef MINMAX_INDEX_EN
                max_idx_d = smp_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min_q <= '1;
            run_max_q <= '0;
`ifdef MINMAX_INDEX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
`ifdef MINMAX_INDEX_EN
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    assign min_nxt = run_min_d;
    assign max_nxt = run_max_d;
`ifdef MINMAX_INDEX_EN
    assign min_idx_nxt = min_idx_d;
    assign max_idx_nxt = max_idx_d;
`endif

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Scan sequencer: reads len samples over a 1-cycle-latency RAM port, reports min/max with done.
// Define MINMAX_INDEX_EN to add min_idx/max_idx outputs.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              empty,
`ifdef MINMAX_INDEX_EN
    output logic [ADDR_W-1:0] min_idx,
    output logic [ADDR_W-1:0] max_idx,
`endif
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, addr_q, addr_d, len_clamp;
    logic              vld_q;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d, acc_min, acc_max;
    logic              accept, last_addr, load_res;
`ifdef MINMAX_INDEX_EN
    logic [ADDR_W-1:0] idx_q, acc_min_idx, acc_max_idx;
    logic [ADDR_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
`endif

    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    assign accept    = (state_q == ST_IDLE) && start && !abort;
    assign last_addr = (addr_q == len_q - LEN_W'(1));
    // The final sample lands during DRAIN, so results are taken from the accumulator's next value.
    assign load_res  = (state_q == ST_DRAIN) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (len_clamp == '0) ? ST_FIN : ST_SCAN;
            ST_SCAN:  if (abort) state_d = ST_IDLE;
                      else if (last_addr) state_d = ST_DRAIN;
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state_q == ST_SCAN);
        rd_addr = rd_en ? addr_q[ADDR_W-1:0] : '0;
        busy    = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
        done    = (state_q == ST_FIN);
    end

    always_comb begin
        len_d   = len_q;
        addr_d  = addr_q;
        empty_d = empty_q;
        min_d   = min_q;
        max_d   = max_q;
`ifdef MINMAX_INDEX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        if (accept) begin
            len_d  = len_clamp;
            addr_d = '0;
            if (len_clamp == '0) empty_d = 1'b1;
        end
        if (state_q == ST_SCAN) addr_d = addr_q + LEN_W'(1);
        if (load_res) begin
            empty_d = 1'b0;
            min_d   = acc_min;
            max_d   = acc_max;
`ifdef MINMAX_INDEX_EN
            min_idx_d = acc_min_idx;
            max_idx_d = acc_max_idx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            empty_q <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
`ifdef MINMAX_INDEX_EN
            idx_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            len_q   <= len_d;
            addr_q  <= addr_d;
            vld_q   <= rd_en;
            empty_q <= empty_d;
            min_q   <= min_d;
            max_q   <= max_d;
`ifdef MINMAX_INDEX_EN
            idx_q     <= rd_addr;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    minmax_accum #(
        .DATA_W (DATA_W)
`ifdef MINMAX_INDEX_EN
        ,
        .ADDR_W (ADDR_W)
`endif
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (accept),
        .smp_vld     (vld_q),
        .smp_data    (rd_data),
`ifdef MINMAX_INDEX_EN
        .smp_idx     (idx_q),
        .min_idx_nxt (acc_min_idx),
        .max_idx_nxt (acc_max_idx),
`endif
        .min_nxt     (acc_min),
        .max_nxt     (acc_max)
    );

    assign empty   = empty_q;
    assign min_val = min_q;
    assign max_val = max_q;
`ifdef MINMAX_INDEX_EN
    assign min_idx = min_idx_q;
    assign max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl: transaction-level model checked every cycle, plus directed literal checks.
module tb_minmax_scan_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;
  localparam int DEPTH  = 16;

  // Handshake: start is a request sampled only while idle; done is a single-cycle
  // completion strobe; rd_data answers rd_en/rd_addr exactly one cycle later.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              busy, done, empty;
  logic [DATA_W-1:0] min_val, max_val;
`ifdef MINMAX_INDEX_EN
  logic [ADDR_W-1:0] min_idx, max_idx;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  minmax_scan_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .empty   (empty),
`ifdef MINMAX_INDEX_EN
    .min_idx (min_idx),
    .max_idx (max_idx),
`endif
    .min_val (min_val),
    .max_val (max_val)
  );

  // synchronous-read sample RAM
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A scan is a transaction: m_rel counts cycles since acceptance; the whole output
  // schedule follows from N = clamped length.
  bit              m_act = 1'b0;
  int              m_rel = 0, m_n = 0, m_last = 0;
  logic [DATA_W-1:0] m_min = '0, m_max = '0;
  bit              m_empty = 1'b0;
  int              m_min_idx = 0, m_max_idx = 0;

  function automatic void m_result();
    if (m_n == 0) begin
      m_empty = 1'b1;
    end else begin
      m_empty = 1'b0;
      m_min = mem[0]; m_max = mem[0]; m_min_idx = 0; m_max_idx = 0;
      for (int i = 1; i < m_n; i++) begin
        if (mem[i] < m_min) begin m_min = mem[i]; m_min_idx = i; end
        if (mem[i] > m_max) begin m_max = mem[i]; m_max_idx = i; end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_rel = 0; m_n = 0; m_last = 0;
      m_min = '0; m_max = '0; m_empty = 1'b0; m_min_idx = 0; m_max_idx = 0;
    end else if (m_act) begin
      if (m_rel == m_last || abort) m_act = 1'b0;
      else begin
        m_rel++;
        if (m_rel == m_last) m_result();
      end
    end else if (start && !abort) begin
      m_n    = (int'(len) > DEPTH) ? DEPTH : int'(len);
      m_last = (m_n == 0) ? 1 : m_n + 2;
      m_act  = 1'b1;
      m_rel  = 1;
      if (m_rel == m_last) m_result();
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      bit e_rd, e_busy, e_done;
      e_rd   = m_act && m_rel >= 1 && m_rel <= m_n;
      e_busy = m_act && m_n > 0 && m_rel <= m_n + 1;
      e_done = m_act && m_rel == m_last;
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      if (e_rd) chk("rd_addr", 32'(rd_addr), 32'(m_rel - 1));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("empty", 32'(empty), 32'(m_empty));
      chk("min_val", 32'(min_val), 32'(m_min));
      chk("max_val", 32'(max_val), 32'(m_max));
`ifdef MINMAX_INDEX_EN
      chk("min_idx", 32'(min_idx), 32'(m_min_idx));
      chk("max_idx", 32'(max_idx), 32'(m_max_idx));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_scan(input int l, output int done_cyc, output int rd_cnt);
    bit seen;
    seen = 1'b0; done_cyc = -1; rd_cnt = 0;
    @(posedge clk); #1; start = 1'b1; len = LEN_W'(l);
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (done) begin done_cyc = k; seen = 1'b1; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL scan_timeout actual=no_done required=done len=%0d", l);
    end
  endtask

  task automatic wait_idle();
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 60 && m_act; k++) @(posedge clk);
    if (m_act) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd0);
    chk({tag, "_min"}, 32'(min_val), 32'd0);
    chk({tag, "_max"}, 32'(max_val), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, rc, nd;
    int dpos [2];
    logic [DATA_W-1:0] pat [8];
    pat = '{8'd7, 8'd3, 8'd9, 8'd3, 8'd12, 8'd0, 8'd12, 8'd5};
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) mem[i] = pat[i];

    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    do_scan(8, dc, rc);
    chk("s8_done_cycle", 32'(dc), 32'd10);
    chk("s8_rd_cycles", 32'(rc), 32'd8);
    chk("s8_min", 32'(min_val), 32'd0);
    chk("s8_max", 32'(max_val), 32'd12);
    chk("s8_empty", 32'(empty), 32'd0);
`ifdef MINMAX_INDEX_EN
    chk("s8_min_idx", 32'(min_idx), 32'd5);
    chk("s8_max_idx", 32'(max_idx), 32'd4);
`endif

    do_scan(0, dc, rc);
    chk("s0_done_cycle", 32'(dc), 32'd1);
    chk("s0_rd_cycles", 32'(rc), 32'd0);
    chk("s0_empty", 32'(empty), 32'd1);
    chk("s0_min_hold", 32'(min_val), 32'd0);
    chk("s0_max_hold", 32'(max_val), 32'd12);

    // abort during cycle 4 of a len=8 scan
    @(posedge clk); #1; start = 1'b1; len = LEN_W'(8);
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    nd = 0;
    repeat (12) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_min_hold", 32'(min_val), 32'd0);
    chk("abort_max_hold", 32'(max_val), 32'd12);
    chk("abort_empty_hold", 32'(empty), 32'd1);

    mem[0] = 8'hFF;
    do_scan(1, dc, rc);
    chk("s1_done_cycle", 32'(dc), 32'd3);
    chk("s1_min", 32'(min_val), 32'hFF);
    chk("s1_max", 32'(max_val), 32'hFF);

    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    do_scan(16, dc, rc);
    chk("s16_done_cycle", 32'(dc), 32'd18);
    chk("s16_rd_cycles", 32'(rc), 32'd16);
    chk("s16_min", 32'(min_val), 32'd0);
    chk("s16_max", 32'(max_val), 32'd15);

    do_scan(31, dc, rc);
    chk("clamp_done_cycle", 32'(dc), 32'd18);
    chk("clamp_rd_cycles", 32'(rc), 32'd16);

    // start held high across back-to-back len=4 scans
    @(posedge clk); #1; start = 1'b1; len = LEN_W'(4);
    @(posedge clk);
    nd = 0; dpos[0] = -1; dpos[1] = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        if (nd < 2) dpos[nd] = k;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_ndone", 32'(nd), 32'd2);
    chk("held_done0", 32'(dpos[0]), 32'd6);
    chk("held_done1", 32'(dpos[1]), 32'd13);
    wait_idle();

    // randomized traffic, memory refreshed only while idle
    for (int b = 0; b < 4; b++) begin
      wait_idle();
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 255));
      if (b == 1) for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 3));
      repeat (150) begin
        @(posedge clk); #1;
        start = ($urandom_range(0, 2) == 0);
        len   = LEN_W'($urandom_range(0, 20));
        abort = ($urandom_range(0, 15) == 0);
      end
    end
    wait_idle();

    // asynchronous reset in the middle of a scan
    mem[3] = 8'hA5;
    @(posedge clk); #1; start = 1'b1; len = LEN_W'(8);
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_rd_en", 32'(rd_en), 32'd1);
    chk("pre_rst_max_nz", 32'(max_val != 0), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;

    do_scan(5, dc, rc);
    chk("post_rst_done_cycle", 32'(dc), 32'd7);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
